// File: rtl/fpu_top.sv
// ============================================================================
// fpu_top : binary32 add/sub/multiply, DAZ/FTZ, RNE, registered result+flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        error,
  output logic        underflow,
  output logic        overflow
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa = a[31];
  assign sb = b[31] ^ (op == 2'b01);  // subtract = add with b negated
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // Multiply significand path
  logic [47:0]       prod;
  logic signed [9:0] mul_exp0, mul_exp;
  logic [23:0]       mul_mant;
  logic              mul_g, mul_st;

  assign prod     = {1'b1, fa} * {1'b1, fb};
  assign mul_exp0 = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  always_comb begin
    if (prod[47]) begin
      mul_mant = prod[47:24];
      mul_g    = prod[23];
      mul_st   = |prod[22:0];
      mul_exp  = mul_exp0 + 10'sd1;
    end else begin
      mul_mant = prod[46:23];
      mul_g    = prod[22];
      mul_st   = |prod[21:0];
      mul_exp  = mul_exp0;
    end
  end

  // Add/sub path: 27-bit significands carry guard/round/sticky below the LSB
  logic              a_big, add_sign, add_zero, add_g, add_st;
  logic [7:0]        e_l, e_s, d;
  logic [26:0]       m_l, m_s, m_sh, m_lost, m_al, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] add_exp;
  logic [23:0]       add_mant;

  assign a_big = {ea, fa} >= {eb, fb};

  always_comb begin
    if (a_big) begin
      e_l = ea; e_s = eb; add_sign = sa;
      m_l = {1'b1, fa, 3'b000};
      m_s = {1'b1, fb, 3'b000};
    end else begin
      e_l = eb; e_s = ea; add_sign = sb;
      m_l = {1'b1, fb, 3'b000};
      m_s = {1'b1, fa, 3'b000};
    end
    d      = e_l - e_s;
    m_sh   = m_s >> d[4:0];
    m_lost = m_s & ~(27'h7FFFFFF << d[4:0]);
    if (d >= 8'd27) m_al = 27'd1;
    else            m_al = {m_sh[26:1], m_sh[0] | (|m_lost)};
    sum = (sa ^ sb) ? ({1'b0, m_l} - {1'b0, m_al}) : ({1'b0, m_l} + {1'b0, m_al});
    add_zero = (sum == 28'd0);
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm    = {sum[27:2], sum[1] | sum[0]};
      add_exp = $signed({2'b00, e_l}) + 10'sd1;
    end else begin
      norm    = sum[26:0] << lz;
      add_exp = $signed({2'b00, e_l}) - $signed({5'b00000, lz});
    end
    add_mant = norm[26:3];
    add_g    = norm[2];
    add_st   = |norm[1:0];
  end

  // Shared round-to-nearest-even and pack
  logic              p_sign, p_g, p_st, r_inc, pk_of, pk_uf;
  logic signed [9:0] p_exp, r_exp;
  logic [23:0]       p_mant;
  logic [24:0]       r_m;
  logic [31:0]       packed_res;

  assign p_sign = op[1] ? (sa ^ sb) : add_sign;
  assign p_exp  = op[1] ? mul_exp   : add_exp;
  assign p_mant = op[1] ? mul_mant  : add_mant;
  assign p_g    = op[1] ? mul_g     : add_g;
  assign p_st   = op[1] ? mul_st    : add_st;

  assign r_inc = p_g & (p_st | p_mant[0]);
  assign r_m   = {1'b0, p_mant} + {24'd0, r_inc};
  assign r_exp = r_m[24] ? (p_exp + 10'sd1) : p_exp;
  assign pk_of = (r_exp > 10'sd254);
  assign pk_uf = (r_exp < 10'sd1);

  always_comb begin
    if (pk_of)      packed_res = {p_sign, 8'hFF, 23'd0};
    else if (pk_uf) packed_res = {p_sign, 31'd0};
    else            packed_res = {p_sign, r_exp[7:0], (r_m[24] ? 23'd0 : r_m[22:0])};
  end

  logic [31:0] nxt_res;
  logic        nxt_err, nxt_uf, nxt_of;

  always_comb begin
    nxt_res = 32'd0;
    nxt_err = 1'b0;
    nxt_uf  = 1'b0;
    nxt_of  = 1'b0;
    case (op)
      2'b11: begin
        nxt_res = QNAN;
        nxt_err = 1'b1;
      end
      2'b10: begin
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
          nxt_res = QNAN;
          nxt_err = 1'b1;
        end else if (a_inf || b_inf) begin
          nxt_res = {sa ^ sb, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
          nxt_res = {sa ^ sb, 31'd0};
        end else begin
          nxt_res = packed_res;
          nxt_of  = pk_of;
          nxt_uf  = pk_uf;
        end
      end
      default: begin
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          nxt_res = QNAN;
          nxt_err = 1'b1;
        end else if (a_inf) begin
          nxt_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
          nxt_res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
          nxt_res = {sa & sb, 31'd0};
        end else if (a_zero) begin
          nxt_res = {sb, b[30:0]};
        end else if (b_zero) begin
          nxt_res = a;
        end else if (add_zero) begin
          nxt_res = 32'd0;
        end else begin
          nxt_res = packed_res;
          nxt_of  = pk_of;
          nxt_uf  = pk_uf;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= 32'd0;
      error     <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      result    <= nxt_res;
      error     <= nxt_err;
      underflow <= nxt_uf;
      overflow  <= nxt_of;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_top.sv
// ============================================================================
// tb_fpu_top : directed vectors with a queue-based scoreboard for fpu_top
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_top;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        error, underflow, overflow;

  fpu_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .error     (error),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flags;  // {error, underflow, overflow}
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got_r, input logic [2:0] got_f,
                       input logic [31:0] want_r, input logic [2:0] want_f);
    n_total++;
    if (got_r === want_r && got_f === want_f) n_pass++;
    else $display("FAIL %s: got result=%h eu o=%b, want result=%h eu o=%b",
                  name, got_r, got_f, want_r, want_f);
  endtask

  // Monitor: each registered output is one cycle after its stimulus
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, result, {error, underflow, overflow}, e.res, e.flags);
    end
  end

  task automatic apply(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input logic [2:0] f);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y;
    e.name = name; e.res = r; e.flags = f;
    q.push_back(e);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    #12;
    check("reset_state", result, {error, underflow, overflow}, 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("mul_3x2",       2'b10, 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000);
    apply("mul_inf_inf",   2'b10, 32'h7F800000, 32'h7F800000, 32'h7F800000, 3'b000);
    apply("mul_overflow",  2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b001);
    apply("mul_underflow", 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
    apply("mul_daz",       2'b10, 32'h00000001, 32'h40000000, 32'h00000000, 3'b000);
    apply("mul_nan_in",    2'b10, 32'hFFC00000, 32'h40A00000, 32'h7FC00000, 3'b100);
    apply("mul_inf_zero",  2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    apply("mul_neg",       2'b10, 32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000);
    apply("mul_zero_sign", 2'b10, 32'h00000000, 32'hC0000000, 32'h80000000, 3'b000);
    apply("mul_round",     2'b10, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    apply("add_1p2",       2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
    apply("sub_equal",     2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000);
    apply("add_inf_ninf",  2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100);
    apply("sub_inf_inf",   2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100);
    apply("sub_3m1",       2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
    apply("add_tie_even",  2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000);
    apply("add_tie_odd",   2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000);
    apply("sub_cancel",    2'b01, 32'h3F800001, 32'h3F800000, 32'h34000000, 3'b000);
    apply("sub_underflow", 2'b01, 32'h00800001, 32'h00800000, 32'h00000000, 3'b010);
    apply("add_nzero",     2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
    apply("add_inf_fin",   2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
    apply("add_overflow",  2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b001);
    apply("reserved_op",   2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3'b100);
    apply("pre_reset",     2'b10, 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000);
    drain();

    // Asynchronous reset mid-cycle with nonzero outputs held
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", result, {error, underflow, overflow}, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    check("held_reset", result, {error, underflow, overflow}, 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset", 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_top.md
Name: fpu_top

Overview:
- Single-precision (IEEE-754 binary32) arithmetic unit performing add, subtract or multiply on two operands, selected by a 2-bit opcode.
- Registered output stage: result and status flags update once per clock.
- Sits as the arithmetic leaf of the FP datapath; flags feed the exception/status logic.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- op  input  2  operation select: 00 add, 01 subtract (a-b), 10 multiply, 11 reserved
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- result  output  32  binary32 result, registered
- error  output  1  invalid operation / NaN result, registered
- underflow  output  1  finite nonzero result flushed to zero, registered
- overflow  output  1  finite operands produced a result too large, registered

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low.
  - While rst_n=0: result=32'h00000000, error=0, underflow=0, overflow=0.
  - Deassertion takes effect at the next clk rising edge.
- Datapath and latency:
  - Combinational compute from op/a/b, captured into the output register on each rising clk edge.
  - Latency exactly 1 cycle; throughput 1 operation per cycle.
  - No handshake; inputs are sampled every edge.
- Denormals (DAZ/FTZ):
  - Input with exp=0 is treated as signed zero.
  - Output whose exponent falls below 1 is flushed to signed zero.
- Rounding: round-to-nearest-even on the 24-bit significand, using guard/round/sticky bits.
- NaN and invalid handling:
  - Any NaN input (exp=FF, frac≠0): result=7FC00000, error=1.
  - Invalid operations also give result=7FC00000, error=1:
    - Inf*0 or 0*Inf.
    - Inf + (-Inf) for add.
    - Inf - Inf (same signs) for sub.
  - op=11 (reserved): result=7FC00000, error=1, other flags 0.
- Infinity:
  - Inf operand with a valid combination yields correctly signed Inf.
  - overflow=0 in this case (exact infinity).
- Overflow: finite operands whose rounded exponent is ≥255 give ±Inf (7F800000/FF800000) and overflow=1.
- Underflow: finite nonzero operands whose result exponent falls below 1 give signed zero and underflow=1.
- Zeros:
  - Exact zero result from add/sub is +0 (round-to-nearest).
  - Multiply sign = sign(a) XOR sign(b).
  - Zero operand with a finite operand gives signed zero, no flags.
- Add/sub:
  - Subtract is implemented as add with b's sign inverted.
  - Align the smaller exponent with a sticky shift.
  - Add or subtract the significands, then normalize with a leading-zero count.
- Multiply:
  - Exponent = ea+eb-127.
  - 24x24-bit significand product, normalized by at most one position.
- Flags:
  - At most one of overflow/underflow is asserted per cycle.
  - error excludes both.
  - Flags are not sticky; they reflect the current registered result only.

Test Plan:
- op=10, a=40400000 (3.0), b=40000000 (2.0) -> after 1 clk: result=40C00000 (6.0), all flags 0.
- op=10, a=7F800000, b=7F800000 -> result=7F800000, error=0, overflow=0, underflow=0. Then a=7F7FFFFF, b=40000000 -> result=7F800000, overflow=1.
- op=10, a=00800000, b=00800000 -> result=00000000, underflow=1, others 0. Then a=00000001, b=40000000 -> result=00000000, all flags 0 (DAZ).
- op=10, a=FFC00000, b=40A00000 -> result=7FC00000, error=1. Then a=7F800000, b=00000000 -> result=7FC00000, error=1.
- op=00, a=3F800000, b=40000000 -> result=40400000. op=01, a=b=3F800000 -> result=00000000. op=00, a=7F800000, b=FF800000 -> result=7FC00000, error=1.
- Assert rst_n=0 asynchronously mid-operation with nonzero outputs -> outputs go to 0 immediately without a clk edge. Release -> the next edge computes from the current inputs.
